// File: rtl/ula_sub_arbiter.sv
// ula_sub_arbiter
// Shares one tri-stated 8-bit subtractor of the ULA between two requesters.
// A round-robin grant latches the winner's operands onto sub_a/sub_b, the
// subtractor's bus driver is enabled for exactly one cycle (OPER), the 9-bit
// bus value is registered into result, and the winner gets a one-cycle ack
// (DONE). Outside OPER the subtractor leaves the shared bus to other units.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req0/a0/b0/ack0  requester 0: request, minuend, subtrahend, done pulse
//   req1/a1/b1/ack1  requester 1: same
//   sub_a, sub_b     operands presented to the subtractor
//   sub_en           subtractor tri-state enable (high in OPER only)
//   sub_s            shared result bus {borrow, diff}
//   result           registered result, held until the next capture
//   busy             high whenever not IDLE
module ula_sub_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack1,
  output logic [7:0] sub_a,
  output logic [7:0] sub_b,
  output logic       sub_en,
  input  logic [8:0] sub_s,
  output logic [8:0] result,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OPER, DONE} state_t;

  state_t state, state_nxt;
  // last doubles as the owner of the operation in flight: it is written on
  // every grant and only read by arbitration in IDLE.
  logic   last;
  logic   take;
  logic   win;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    // contested -> the one not served last; otherwise whoever is asking
    win       = (req0 && req1) ? ~last : req1;
    case (state)
      IDLE: if (req0 || req1) begin
        take      = 1'b1;
        state_nxt = OPER;
      end
      OPER:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      sub_a  <= '0;
      sub_b  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        last  <= win;
        sub_a <= win ? a1 : a0;
        sub_b <= win ? b1 : b0;
      end
      if (state == OPER) result <= sub_s;
    end
  end

  // Decoded straight from the state register so an asynchronous reset
  // releases the bus and kills any ack in the same instant.
  assign sub_en = (state == OPER);
  assign ack0   = (state == DONE) && !last;
  assign ack1   = (state == DONE) &&  last;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ula_sub_arbiter.sv
module tb_ula_sub_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       ack0, ack1, sub_en, busy;
  logic [7:0] sub_a, sub_b;
  logic [8:0] sub_s, result;

  always #5 clk = ~clk;

  // Subtractor unit on the shared bus; when it is not enabled another ULA
  // unit is assumed to drive a recognisable junk value.
  always_comb sub_s = sub_en ? ({1'b0, sub_a} - {1'b0, sub_b}) : 9'h1AA;

  ula_sub_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .sub_a(sub_a), .sub_b(sub_b), .sub_en(sub_en), .sub_s(sub_s),
    .result(result), .busy(busy)
  );

  int tests = 0, fails = 0;

  // timeline reference model: a grant at the edge ending cycle c puts the
  // enable in c+1, the ack in c+2 and frees the unit for a grant at c+3
  int         cyc = 0, en_cyc = -1, ack_cyc = -1, free_at = 0;
  int         m_owner = 0, m_last = 1;
  logic [7:0] m_sa = '0, m_sb = '0;
  logic [8:0] m_res = '0, m_next = '0;
  int         ackq[$];
  bit         hold0 = 0, hold1 = 0, rnd = 0;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_sa = '0; m_sb = '0; m_res = '0;
    en_cyc = -1; ack_cyc = -1; free_at = 0;
  endtask

  task automatic model_edge();
    int g, d;
    if (cyc == en_cyc) m_res = m_next;
    if (cyc >= free_at && (req0 || req1)) begin
      if (req0 && req1) g = 1 - m_last;
      else              g = req0 ? 0 : 1;
      m_last  = g;
      m_owner = g;
      m_sa    = g ? a1 : a0;
      m_sb    = g ? b1 : b0;
      d       = int'(m_sa) - int'(m_sb);
      m_next  = {(d < 0) ? 1'b1 : 1'b0, 8'((d + 256) % 256)};
      en_cyc  = cyc + 1;
      ack_cyc = cyc + 2;
      free_at = cyc + 3;
    end
  endtask

  task automatic check_cycle();
    chk("sub_en", {8'b0, sub_en}, {8'b0, cyc == en_cyc});
    chk("ack0",   {8'b0, ack0},   {8'b0, cyc == ack_cyc && m_owner == 0});
    chk("ack1",   {8'b0, ack1},   {8'b0, cyc == ack_cyc && m_owner == 1});
    chk("busy",   {8'b0, busy},   {8'b0, cyc == en_cyc || cyc == ack_cyc});
    chk("result", result, m_res);
    chk("sub_a",  {1'b0, sub_a}, {1'b0, m_sa});
    chk("sub_b",  {1'b0, sub_b}, {1'b0, m_sb});
    chk("excl",   {8'b0, (2'(sub_en) + 2'(ack0) + 2'(ack1)) > 2'd1}, 9'h000);
    if (ack0) ackq.push_back(0);
    if (ack1) ackq.push_back(1);
  endtask

  // requester behaviour: drop req at the edge ending the ack cycle unless
  // holding; in random mode idle requesters raise new requests
  task automatic react();
    bit d0, d1;
    d0 = 0; d1 = 0;
    if (!rst && cyc == ack_cyc) begin
      if (m_owner == 0 && !hold0) begin req0 = 1'b0; d0 = 1; end
      if (m_owner == 1 && !hold1) begin req1 = 1'b0; d1 = 1; end
    end
    if (rnd) begin
      if (!req0 && !d0 && $urandom_range(0, 2) == 0) begin
        a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
      end
      if (!req1 && !d1 && $urandom_range(0, 2) == 0) begin
        a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    cyc++;
    #1;
    check_cycle();
    react();
  endtask

  initial begin
    int n;
    // reset values
    #2;
    chk("rst_sub_en", {8'b0, sub_en}, 9'h000);
    chk("rst_busy",   {8'b0, busy},   9'h000);
    chk("rst_ack",    {7'b0, ack1, ack0}, 9'h000);
    chk("rst_result", result, 9'h000);
    chk("rst_sub_a",  {1'b0, sub_a}, 9'h000);
    step(); step();
    rst = 1'b0;
    step();

    // single request
    a0 = 8'h05; b0 = 8'h03; req0 = 1'b1;
    step(); chk("single_en", {8'b0, sub_en}, 9'h001);
    step(); chk("single_res", result, 9'h002);
    chk("single_ack0", {8'b0, ack0}, 9'h001);
    chk("single_ack1", {8'b0, ack1}, 9'h000);
    step(); chk("single_en_off", {8'b0, sub_en}, 9'h000);

    // borrow cases
    a1 = 8'h03; b1 = 8'h05; req1 = 1'b1;
    step(); step();
    chk("borrow_res", result, 9'h1FE);
    chk("borrow_ack1", {8'b0, ack1}, 9'h001);
    step();
    a1 = 8'h00; b1 = 8'hFF; req1 = 1'b1;
    step(); step();
    chk("borrow2_res", result, 9'h101);
    step();

    // reset in the middle of OPER
    a0 = 8'h22; b0 = 8'h11; req0 = 1'b1;
    step(); chk("pre_rst_en", {8'b0, sub_en}, 9'h001);
    rst = 1'b1;
    #1;
    chk("mid_rst_en",     {8'b0, sub_en}, 9'h000);
    chk("mid_rst_ack",    {7'b0, ack1, ack0}, 9'h000);
    chk("mid_rst_busy",   {8'b0, busy}, 9'h000);
    chk("mid_rst_result", result, 9'h000);
    model_reset();
    req0 = 1'b0;
    step(); step();
    rst = 1'b0;
    step(); step(); step();

    // contention held from reset release: grants 0,1,0,1
    rst = 1'b1;
    model_reset();
    a0 = 8'h40; b0 = 8'h01; a1 = 8'h07; b1 = 8'h09;
    req0 = 1'b1; req1 = 1'b1; hold0 = 1; hold1 = 1;
    step();
    rst = 1'b0;
    ackq.delete();
    for (int i = 0; i < 12; i++) step();
    chk("cont_nacks", 9'(ackq.size()), 9'd4);
    if (ackq.size() == 4) begin
      chk("cont_g0", 9'(ackq[0]), 9'd0);
      chk("cont_g1", 9'(ackq[1]), 9'd1);
      chk("cont_g2", 9'(ackq[2]), 9'd0);
      chk("cont_g3", 9'(ackq[3]), 9'd1);
    end
    req0 = 1'b0; req1 = 1'b0; hold0 = 0; hold1 = 0;
    step(); step();

    // hold semantics: back-to-back services of requester 0
    a0 = 8'h10; b0 = 8'h01; req0 = 1'b1; hold0 = 1;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (ack0) begin
        n++;
        chk("hold_res", result, 9'h00F);
      end
    end
    chk("hold_nacks", 9'(n), 9'd3);
    req0 = 1'b0; hold0 = 0;
    step(); step();

    // random request mix, then drain
    rnd = 1;
    for (int i = 0; i < 300; i++) step();
    rnd = 0;
    for (int i = 0; i < 8; i++) step();
    chk("drain_busy", {8'b0, busy}, 9'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
